// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and a parity helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Raw encodings are kept as localparams so the transmit side can reuse them.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    StIdle     = ST_IDLE,
    StStart    = ST_START,
    StData     = ST_DATA,
    StParity   = ST_PARITY,
    StStop     = ST_STOP,
    StWaitIdle = ST_WAIT_IDLE
  } uart_state_e;

  // Expected parity bit for up to 9 data bits; narrower words are zero-extended.
  function automatic logic par_calc(input logic [8:0] data, input int unsigned mode);
    logic p;
    p = 1'b0;
    if (mode == PARITY_EVEN) p = ^data;
    else if (mode == PARITY_ODD) p = ~^data;
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divider 0..ClkDiv-1, single-cycle tick on wrap.
// Ports: clk_i clock, rst_i async active-high reset, restart_i synchronous phase restart,
//        tick_o one-cycle tick.
module uart_baud_tick #(
  parameter int unsigned ClkDiv = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || cnt_q == CntMax) cnt_d = '0;
  end

  assign tick_o = (cnt_q == CntMax);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote oversampling and a valid/ready output.
// Ports: clk, rst (async active-high), rx serial in (idles high),
//        m_data/m_perr/m_ferr/m_valid/m_ready output stream, overrun drop pulse, busy.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CLK_DIV    = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned OsW = $clog2(OVERSAMPLE);
  localparam logic [OsW-1:0] SampA  = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0] SampB  = OsW'(OVERSAMPLE / 2);
  localparam logic [OsW-1:0] SampC  = OsW'(OVERSAMPLE / 2 + 1);
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  uart_state_e state_d, state_q;
  logic [OsW-1:0] os_cnt_d, os_cnt_q;
  logic [3:0] bit_cnt_d, bit_cnt_q;
  logic [1:0] samp_d, samp_q;
  logic [DATA_BITS-1:0] shreg_d, shreg_q;
  logic perr_d, perr_q, ferr_d, ferr_q, done_d, done_q;
  logic [DATA_BITS-1:0] m_data_d, m_data_q;
  logic m_perr_d, m_perr_q, m_ferr_d, m_ferr_q, m_valid_d, m_valid_q, overrun_d, overrun_q;
  logic restart, tick, vote;

  uart_baud_tick #(
    .ClkDiv(CLK_DIV)
  ) u_tick (
    .clk_i    (clk),
    .rst_i    (rst),
    .restart_i(restart),
    .tick_o   (tick)
  );

  // Third sample is taken live from the synchroniser on the deciding tick.
  assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s2_q) | (samp_q[0] & rx_s2_q);

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    samp_d    = samp_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    restart   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          state_d   = StStart;
          restart   = 1'b1;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end
      StWaitIdle: begin
        if (rx_s2_q) state_d = StIdle;
      end
      default: begin
        if (tick) begin
          os_cnt_d = (os_cnt_q == OsLast) ? '0 : os_cnt_q + 1'b1;
          if (os_cnt_q == SampA || os_cnt_q == SampB) samp_d = {samp_q[0], rx_s2_q};
          if (os_cnt_q == SampC) begin
            case (state_q)
              StStart: begin
                if (vote) state_d = StIdle;
                perr_d = 1'b0;
                ferr_d = 1'b0;
              end
              StData:   shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
              StParity: perr_d = vote ^ par_calc(9'(shreg_q), PARITY);
              StStop: begin
                if (!vote) ferr_d = 1'b1;
                if (bit_cnt_q == StopLast) begin
                  done_d  = 1'b1;
                  state_d = vote ? StIdle : StWaitIdle;
                end
              end
              default: ;
            endcase
          end
          if (os_cnt_q == OsLast) begin
            case (state_q)
              StStart: begin
                state_d   = StData;
                bit_cnt_d = '0;
              end
              StData: begin
                if (bit_cnt_q == DataLast) begin
                  state_d   = (PARITY != PARITY_NONE) ? StParity : StStop;
                  bit_cnt_d = '0;
                end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                end
              end
              StParity: begin
                state_d   = StStop;
                bit_cnt_d = '0;
              end
              StStop:  bit_cnt_d = bit_cnt_q + 1'b1;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Output register: a completed word loads only if the slot is free or being drained.
  always_comb begin
    m_data_d  = m_data_q;
    m_perr_d  = m_perr_q;
    m_ferr_d  = m_ferr_q;
    m_valid_d = m_valid_q;
    overrun_d = 1'b0;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (done_q) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = shreg_q;
        m_perr_d  = perr_q;
        m_ferr_d  = ferr_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      samp_q    <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      m_data_q  <= '0;
      m_perr_q  <= 1'b0;
      m_ferr_q  <= 1'b0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      samp_q    <= samp_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
      m_data_q  <= m_data_d;
      m_perr_q  <= m_perr_d;
      m_ferr_q  <= m_ferr_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_perr  = m_perr_q;
  assign m_ferr  = m_ferr_q;
  assign m_valid = m_valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int BitClk = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1, rx_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

  logic [7:0] m_data_a, m_data_b;
  logic [6:0] m_data_c;
  logic m_perr_a, m_ferr_a, m_valid_a, overrun_a, busy_a;
  logic m_perr_b, m_ferr_b, m_valid_b, overrun_b, busy_b;
  logic m_perr_c, m_ferr_c, m_valid_c, overrun_c, busy_c;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .m_data(m_data_a), .m_perr(m_perr_a), .m_ferr(m_ferr_a),
    .m_valid(m_valid_a), .m_ready(ready_a), .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .CLK_DIV(2)) u_b (
    .clk(clk), .rst(rst), .rx(rx_a), .m_data(m_data_b), .m_perr(m_perr_b), .m_ferr(m_ferr_b),
    .m_valid(m_valid_b), .m_ready(ready_b), .overrun(overrun_b), .busy(busy_b)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16), .CLK_DIV(2)) u_c (
    .clk(clk), .rst(rst), .rx(rx_c), .m_data(m_data_c), .m_perr(m_perr_c), .m_ferr(m_ferr_c),
    .m_valid(m_valid_c), .m_ready(ready_c), .overrun(overrun_c), .busy(busy_c)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       perr_a;
    logic       perr_b;
    logic       ferr;
  } vec_t;

  word_t qa[$], qb[$], qc[$];
  int n_checks = 0;
  int n_fail = 0;
  int ovr_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_a(input logic v, input int nbits);
    rx_a = v;
    wait_clk(BitClk * nbits);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic pbit, input logic stop);
    bit_a(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_a(d[i], 1);
    bit_a(pbit, 1);
    bit_a(stop, 1);
    rx_a = 1'b1;
  endtask

  task automatic bit_c(input logic v);
    rx_c = v;
    wait_clk(BitClk);
  endtask

  task automatic pop_a(input string name, input logic [7:0] d, input logic pe, input logic fe);
    word_t w;
    chk({name, "_count"}, qa.size(), 1);
    if (qa.size() > 0) begin
      w = qa.pop_front();
      chk({name, "_data"}, w.data, {1'b0, d});
      chk({name, "_perr"}, w.perr, pe);
      chk({name, "_ferr"}, w.ferr, fe);
    end
    qa.delete();
  endtask

  // Stream monitor: records handshakes, counts overruns, checks output stability while stalled.
  initial begin
    logic  hold;
    word_t held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (m_valid_a && ready_a) qa.push_back('{9'(m_data_a), m_perr_a, m_ferr_a});
        if (m_valid_b && ready_b) qb.push_back('{9'(m_data_b), m_perr_b, m_ferr_b});
        if (m_valid_c && ready_c) qc.push_back('{9'(m_data_c), m_perr_c, m_ferr_c});
        if (overrun_a) ovr_a++;
        if (hold) begin
          n_checks++;
          if ({9'(m_data_a), m_perr_a, m_ferr_a} !== held) begin
            n_fail++;
            $display("FAIL hold_stable: got %0h expected %0h",
                     {9'(m_data_a), m_perr_a, m_ferr_a}, held);
          end
        end
        hold = m_valid_a && !ready_a;
        held = '{9'(m_data_a), m_perr_a, m_ferr_a};
      end
    end
  end

  initial begin
    vec_t vecs[6];
    word_t w;
    logic [6:0] cd;
    logic s1, s2;

    //           data   pbit  stop  perr_a perr_b ferr
    vecs[0] = '{8'h95, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h95, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    wait_clk(3);
    chk("reset_valid", m_valid_a, 0);
    chk("reset_data", m_data_a, 0);
    chk("reset_flags", {m_perr_a, m_ferr_a, overrun_a}, 0);
    chk("reset_busy", busy_a, 0);
    rst = 1'b0;
    wait_clk(10);

    // Table-driven frames on the even (A) and odd (B) parity receivers
    for (int i = 0; i < 6; i++) begin
      frame_a(vecs[i].data, vecs[i].pbit, vecs[i].stop);
      wait_clk(2 * BitClk);
      pop_a($sformatf("vec%0d_a", i), vecs[i].data, vecs[i].perr_a, vecs[i].ferr);
      chk($sformatf("vec%0d_b_count", i), qb.size(), 1);
      if (qb.size() > 0) begin
        w = qb.pop_front();
        chk($sformatf("vec%0d_b_data", i), w.data, {1'b0, vecs[i].data});
        chk($sformatf("vec%0d_b_perr", i), w.perr, vecs[i].perr_b);
        chk($sformatf("vec%0d_b_ferr", i), w.ferr, vecs[i].ferr);
      end
      qb.delete();
      chk($sformatf("vec%0d_valid_low", i), m_valid_a, 0);
    end

    // Glitch shorter than half a bit is rejected
    rx_a = 1'b0;
    wait_clk(10);
    rx_a = 1'b1;
    wait_clk(2);
    chk("glitch_busy_high", busy_a, 1);
    wait_clk(BitClk - 12);
    chk("glitch_busy_low", busy_a, 0);
    wait_clk(BitClk);
    chk("glitch_no_word", qa.size(), 0);

    // Overrun with the consumer stalled
    ready_a = 1'b0;
    ovr_a = 0;
    frame_a(8'h11, 1'b0, 1'b1);
    wait_clk(BitClk);
    frame_a(8'h22, 1'b0, 1'b1);
    wait_clk(2 * BitClk);
    chk("ovr_valid", m_valid_a, 1);
    chk("ovr_data", m_data_a, 8'h11);
    chk("ovr_pulses", ovr_a, 1);
    chk("ovr_no_handshake", qa.size(), 0);
    ready_a = 1'b1;
    wait_clk(3);
    pop_a("ovr_drain", 8'h11, 1'b0, 1'b0);
    chk("ovr_valid_after", m_valid_a, 0);
    qb.delete();

    // Break: stop bit low and line held low for three more bits
    bit_a(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_a(1'b0, 1);
    bit_a(1'b0, 1);
    bit_a(1'b0, 4);
    chk("break_busy", busy_a, 1);
    pop_a("break_word", 8'h00, 1'b0, 1'b1);
    rx_a = 1'b1;
    wait_clk(6);
    chk("break_idle", busy_a, 0);
    wait_clk(BitClk);
    frame_a(8'hA5, 1'b0, 1'b1);
    wait_clk(2 * BitClk);
    pop_a("after_break", 8'hA5, 1'b0, 1'b0);

    // Reset mid-frame with a pending word
    ready_a = 1'b0;
    frame_a(8'h77, 1'b0, 1'b1);
    wait_clk(BitClk);
    chk("rst_pending", m_valid_a, 1);
    bit_a(1'b0, 1);
    bit_a(1'b1, 1);
    bit_a(1'b1, 1);
    bit_a(1'b0, 1);
    chk("rst_busy_pre", busy_a, 1);
    rst = 1'b1;
    #1;
    chk("rst_valid", m_valid_a, 0);
    chk("rst_data", m_data_a, 0);
    chk("rst_flags", {m_perr_a, m_ferr_a, overrun_a}, 0);
    chk("rst_busy", busy_a, 0);
    rx_a = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    ready_a = 1'b1;
    wait_clk(3 * BitClk);
    chk("rst_no_word", qa.size(), 0);
    frame_a(8'h3C, 1'b0, 1'b1);
    wait_clk(2 * BitClk);
    pop_a("after_rst", 8'h3C, 1'b0, 1'b0);
    qb.delete();

    // Sweep: 7 data bits, no parity, 2 stop bits, random data and stop patterns
    for (int n = 0; n < 50; n++) begin
      cd = 7'($urandom_range(0, 127));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      bit_c(1'b0);
      for (int i = 0; i < 7; i++) bit_c(cd[i]);
      bit_c(s1);
      bit_c(s2);
      rx_c = 1'b1;
      wait_clk(BitClk);
      chk($sformatf("sweep%0d_count", n), qc.size(), 1);
      if (qc.size() > 0) begin
        w = qc.pop_front();
        chk($sformatf("sweep%0d_word", n), {w.data, w.perr, w.ferr},
            {2'b00, cd, 1'b0, ~(s1 & s2)});
      end
      qc.delete();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
